fact_mmio_responder: RTL
========================

Name: fact_mmio_responder

Overview:
- Memory-mapped responder for the factorial accelerator; it sits on the MIPS data-memory bus next to the GPIO block.
- The CPU, as initiator, writes N, writes GO, polls STATUS and reads RESULT.
- Computes N! iteratively, one multiply per cycle, with an explicit done/error handshake.

Parameters:
- DW, 32, data/result width.
- N_W, 4, width of the N operand register.
- MAX_N, 12, largest legal N. MAX_N! must be < 2^DW; 12! = 0x1C8CFC00.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- we  in  1  write enable for the current bus cycle.
- addr  in  2  word select (byte address bits [3:2]):
  - 0 = N (RW)
  - 1 = GO (W; reads 0)
  - 2 = STATUS (RO)
  - 3 = RESULT (RO)
- wd  in  DW  write data.
- rd  out  DW  read data; combinational from addr and register state.
- done  out  1  mirror of STATUS[0].
- busy  out  1  mirror of STATUS[2].

Behaviour:
- Reset (rst low, asynchronous) clears everything: state=IDLE, N=0, cnt=0, prod=0, RESULT=0, done=0, err=0, busy=0. rd then reads 0 for every address.
- Reset asserted mid-computation aborts the computation; no partial result is retained.
- STATUS layout: [0] done, [1] err, [2] busy, [DW-1:3] read 0.
- Write to N (we=1, addr=0): N <= wd[N_W-1:0]. Accepted in any state. Does not affect a computation already in progress, because the operand is latched into cnt at GO.
- GO write (we=1, addr=1, wd[0]=1) in IDLE, with N <= MAX_N, at edge k:
  - cnt <= N, prod <= 1
  - done <= 0, err <= 0
  - state <= BUSY (busy=1 from edge k)
- GO write in IDLE with N > MAX_N, at edge k:
  - state stays IDLE
  - RESULT <= 0, err <= 1, done <= 1, all at edge k
- GO write while BUSY: ignored; no restart and no flag change.
- GO write with wd[0]=0: no effect.
- BUSY state, each edge:
  - If cnt > 1: prod <= prod * cnt (DW x N_W product truncated to DW bits; cannot overflow for N <= MAX_N), cnt <= cnt - 1.
  - Else: RESULT <= prod, done <= 1, state <= IDLE.
- Latency: done rises at edge k + max(N,1). N=0 and N=1 both give RESULT=1 at edge k+1.
- done and err are sticky until the next accepted GO.
- RESULT holds its value until the next completion or error.
- Writes to STATUS or RESULT are ignored.
- Simultaneous events:
  - A read in the same cycle as the completion edge returns the old values; the new values are visible in the following cycle.
  - Only one register is written per cycle, so a write to N and a GO cannot coincide.
- FSM has two states, IDLE and BUSY; there is no other state.

Decomposition:
- Shared package fact_pkg holds:
  - address constants ADDR_N=2'd0, ADDR_GO=2'd1, ADDR_STATUS=2'd2, ADDR_RESULT=2'd3
  - STATUS bit indices
  - state encoding IDLE/BUSY
  - MAX_N default
- One sub-module, fact_iter_mul: cnt/prod registers with load/step/last outputs.
- The top level holds the bus decode, the flags and the FSM.

Test Plan:
- N=5, GO at edge k -> busy=1 for edges k..k+4; done=1 at edge k+5; RESULT=0x78; err=0.
- N=0, then N=1 -> each gives done at edge k+1, RESULT=1.
- N=12 -> done at edge k+12, RESULT=0x1C8CFC00.
- N=13 -> done=1, err=1, RESULT=0 at edge k; busy never asserted. A following GO with N=3 clears err and gives RESULT=6 at edge k+3.
- N=6, GO, then at k+2 write N=2 and issue GO again -> the second GO is ignored; RESULT=720 (0x2D0) at edge k+6; a read of N returns 2.
- N=10, GO, rst low at k+4 -> all outputs read 0 immediately. After release, GO with N=4 gives RESULT=24 at edge +4.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared constants for the factorial MMIO responder: register map, STATUS bits,
// FSM encoding and the default operand limit.
package fact_pkg;

  localparam logic [1:0] ADDR_N      = 2'd0;
  localparam logic [1:0] ADDR_GO     = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  localparam int STAT_DONE = 0;
  localparam int STAT_ERR  = 1;
  localparam int STAT_BUSY = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam int MAX_N_DEFAULT = 12;

endpackage

// File: rtl/fact_iter_mul.sv
// Iterative factorial datapath: a down-counter and a running product that
// advances by one multiply per step.
module fact_iter_mul #(
  parameter int DW  = 32,
  parameter int N_W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [N_W-1:0] n,
  output logic [DW-1:0]  prod,
  output logic           last
);

  logic [N_W-1:0] cnt;
  logic [DW-1:0]  cnt_ext;

  assign cnt_ext = DW'(cnt);
  // cnt of 0 or 1 means the product is final, so N=0 and N=1 both finish at 1
  assign last    = (cnt <= N_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      prod <= '0;
    end else if (load) begin
      cnt  <= n;
      prod <= DW'(1);
    end else if (step) begin
      prod <= prod * cnt_ext;
      cnt  <= cnt - N_W'(1);
    end
  end

endmodule

// File: rtl/fact_mmio_responder.sv
// Memory-mapped factorial accelerator: bus decode, done/err flags and the
// IDLE/BUSY sequencer around the iterative multiplier.
module fact_mmio_responder
  import fact_pkg::*;
#(
  parameter int DW    = 32,
  parameter int N_W   = 4,
  parameter int MAX_N = MAX_N_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] rd,
  output logic          done,
  output logic          busy
);

  localparam logic [N_W-1:0] MAX_N_W = N_W'(MAX_N);

  logic [0:0]     state;
  logic [N_W-1:0] n_reg;
  logic [DW-1:0]  result;
  logic           done_r;
  logic           err_r;
  logic [DW-1:0]  prod;
  logic           last;
  logic           wr_n;
  logic           go_req;
  logic           n_ok;
  logic           load;
  logic           step;
  logic [DW-1:0]  status_word;
  logic           unused_wd;

  assign unused_wd = ^wd[DW-1:N_W];

  assign wr_n   = we && (addr == ADDR_N);
  assign go_req = we && (addr == ADDR_GO) && wd[0];
  assign n_ok   = (n_reg <= MAX_N_W);
  assign load   = go_req && (state == ST_IDLE) && n_ok;
  assign step   = (state == ST_BUSY) && !last;

  assign done = done_r;
  assign busy = (state == ST_BUSY);

  fact_iter_mul #(
    .DW  (DW),
    .N_W (N_W)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .n    (n_reg),
    .prod (prod),
    .last (last)
  );

  // GO is only honoured in IDLE; an out-of-range N reports an error without
  // ever entering BUSY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      n_reg  <= '0;
      result <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      if (wr_n) begin
        n_reg <= wd[N_W-1:0];
      end
      if (state == ST_IDLE) begin
        if (go_req) begin
          if (n_ok) begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            state  <= ST_BUSY;
          end else begin
            result <= '0;
            err_r  <= 1'b1;
            done_r <= 1'b1;
          end
        end
      end else if (last) begin
        result <= prod;
        done_r <= 1'b1;
        state  <= ST_IDLE;
      end
    end
  end

  always_comb begin
    status_word            = '0;
    status_word[STAT_DONE] = done_r;
    status_word[STAT_ERR]  = err_r;
    status_word[STAT_BUSY] = busy;
  end

  always_comb begin
    rd = '0;
    case (addr)
      ADDR_N:      rd = DW'(n_reg);
      ADDR_GO:     rd = '0;
      ADDR_STATUS: rd = status_word;
      ADDR_RESULT: rd = result;
      default:     rd = '0;
    endcase
  end

endmodule
